// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the game logic that consumes its events.
package keypad_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StHeld,
      StSwap
   } key_state_e;

   // Code width and NONE sentinel of the standard 4x3 pad; other geometries use all-ones of theirs.
   localparam int unsigned PadCodeW = 4;
   localparam logic [PadCodeW-1:0] KeyNone  = '1;
   localparam logic [PadCodeW-1:0] KeyUp    = 4'd4;
   localparam logic [PadCodeW-1:0] KeyLeft  = 4'd6;
   localparam logic [PadCodeW-1:0] KeyPut   = 4'd7;
   localparam logic [PadCodeW-1:0] KeyRight = 4'd8;
   localparam logic [PadCodeW-1:0] KeyUndo  = 4'd9;
   localparam logic [PadCodeW-1:0] KeyDown  = 4'd10;

   function automatic int unsigned code_of(input int unsigned row, input int unsigned col,
                                           input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row scanner: dwell and row counters, one-hot row drive, column sample strobe and frame marker.
module keypad_row_scan #(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned SCAN_DIV = 8,
   localparam int unsigned RowW    = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   output logic [ROWS-1:0] key_row_o,
   output logic [RowW-1:0] row_idx_o,
   output logic            sample_o,
   output logic            frame_done_o
);

   localparam int unsigned DwellW = $clog2(SCAN_DIV);
   localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
   localparam logic [RowW-1:0]   RowLast   = RowW'(ROWS - 1);

   logic              run_q;
   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [RowW-1:0]   row_q, row_d;

   always_comb begin
      dwell_d = dwell_q;
      row_d   = row_q;
      if (run_q) begin
         if (dwell_q == DwellLast) begin
            dwell_d = '0;
            row_d   = (row_q == RowLast) ? '0 : row_q + RowW'(1);
         end else begin
            dwell_d = dwell_q + DwellW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q   <= 1'b0;
         dwell_q <= '0;
         row_q   <= '0;
      end else begin
         run_q   <= 1'b1;
         dwell_q <= dwell_d;
         row_q   <= row_d;
      end
   end

   // Row r is wired to the MSB-first position ROWS-1-r; nothing is driven until the first clock.
   always_comb begin
      key_row_o = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         key_row_o[ROWS-1-r] = run_q && (row_q == RowW'(r));
      end
   end

   assign row_idx_o    = row_q;
   assign sample_o     = run_q && (dwell_q == DwellLast);
   assign frame_done_o = sample_o && (row_q == RowLast);

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad front end: scan, synchronise, debounce, reject multi-key frames, emit key events.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 3,
   parameter int unsigned SCAN_DIV        = 8,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter bit          REPEAT_EN       = 1'b0,
   parameter int unsigned REPEAT_DELAY    = 32,
   parameter int unsigned REPEAT_RATE     = 8,
   localparam int unsigned CODE_W         = $clog2(ROWS * COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [COLS-1:0]   key_col_i,
   output logic [ROWS-1:0]   key_row_o,
   output logic [CODE_W-1:0] key_code_o,
   output logic              key_valid_o,
   output logic              key_press_o,
   output logic              key_release_o,
   output logic              key_repeat_o,
   output logic              multi_key_o
);

   localparam int unsigned RowW   = $clog2(ROWS);
   localparam int unsigned CntW   = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RepW   = $clog2(RepMax + 1);
   localparam logic [CODE_W-1:0] NoneCode = '1;
   localparam logic [CntW-1:0]   CntFull  = CntW'(DEBOUNCE_FRAMES);

   logic [RowW-1:0]   row_idx;
   logic              sample, frame_done;
   logic [COLS-1:0]   col_meta_q, col_sync_q;
   logic [1:0]        acc_hits_q, row_hits, tot_hits;
   logic [2:0]        hit_sum;
   logic [CODE_W-1:0] acc_code_q, row_code, merged_code, frame_res;
   logic              multi_q;
   logic [CODE_W-1:0] cand_q, cand_d, stable_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              stable_chg;

   key_state_e        state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d, press_q, press_d;
   logic              release_q, release_d, repeat_q, repeat_d;
   logic [RepW-1:0]   rep_cnt_q, rep_cnt_d;

   keypad_row_scan #(
      .ROWS     (ROWS),
      .SCAN_DIV (SCAN_DIV)
   ) u_row_scan (
      .clk          (clk),
      .rst          (rst),
      .key_row_o    (key_row_o),
      .row_idx_o    (row_idx),
      .sample_o     (sample),
      .frame_done_o (frame_done)
   );

   // Hit count saturates at 2: only none / exactly one / several matter.
   always_comb begin
      row_hits = 2'd0;
      row_code = NoneCode;
      for (int unsigned b = 0; b < COLS; b++) begin
         if (col_sync_q[b]) begin
            if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            row_code = CODE_W'(code_of(32'(row_idx), COLS - 1 - b, COLS));
         end
      end
      hit_sum     = {1'b0, acc_hits_q} + {1'b0, row_hits};
      tot_hits    = (hit_sum > 3'd1) ? 2'd2 : hit_sum[1:0];
      merged_code = (acc_hits_q != 2'd0) ? acc_code_q : row_code;
      frame_res   = (tot_hits == 2'd1) ? merged_code : NoneCode;

      if (frame_res != cand_q) begin
         cand_d = frame_res;
         cnt_d  = CntW'(1);
      end else begin
         cand_d = cand_q;
         cnt_d  = (cnt_q == CntFull) ? cnt_q : cnt_q + CntW'(1);
      end
      stable_chg = frame_done && (cnt_d == CntFull) && (cand_d != stable_q);
   end

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      valid_d   = valid_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      rep_cnt_d = rep_cnt_q;
      case (state_q)
         StIdle: begin
            // Entered with valid still high for the release cycle; it drops one clock later.
            valid_d = 1'b0;
            if (stable_chg) begin
               state_d   = StHeld;
               code_d    = cand_d;
               valid_d   = 1'b1;
               press_d   = 1'b1;
               rep_cnt_d = RepW'(REPEAT_DELAY);
            end
         end
         StHeld: begin
            if (stable_chg) begin
               release_d = 1'b1;
               rep_cnt_d = '0;
               state_d   = (cand_d == NoneCode) ? StIdle : StSwap;
            end else if (REPEAT_EN && frame_done) begin
               if (rep_cnt_q == RepW'(1)) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = RepW'(REPEAT_RATE);
               end else begin
                  rep_cnt_d = rep_cnt_q - RepW'(1);
               end
            end
         end
         StSwap: begin
            state_d   = StHeld;
            code_d    = stable_q;
            press_d   = 1'b1;
            rep_cnt_d = RepW'(REPEAT_DELAY);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_q <= '0;
         col_sync_q <= '0;
         acc_hits_q <= 2'd0;
         acc_code_q <= NoneCode;
         multi_q    <= 1'b0;
         cand_q     <= NoneCode;
         cnt_q      <= '0;
         stable_q   <= NoneCode;
         state_q    <= StIdle;
         code_q     <= '0;
         valid_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         repeat_q   <= 1'b0;
         rep_cnt_q  <= '0;
      end else begin
         col_meta_q <= key_col_i;
         col_sync_q <= col_meta_q;
         if (sample) begin
            if (frame_done) begin
               acc_hits_q <= 2'd0;
               acc_code_q <= NoneCode;
               multi_q    <= (tot_hits == 2'd2);
               cand_q     <= cand_d;
               cnt_q      <= cnt_d;
               if (stable_chg) stable_q <= cand_d;
            end else begin
               acc_hits_q <= tot_hits;
               acc_code_q <= merged_code;
            end
         end
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         rep_cnt_q <= rep_cnt_d;
      end
   end

   assign key_code_o    = code_q;
   assign key_valid_o   = valid_q;
   assign key_press_o   = press_q;
   assign key_release_o = release_q;
   assign key_repeat_o  = repeat_q;
   assign multi_key_o   = multi_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce on a 4x3 pad with 16-clock frames and 3-frame debounce.
module tb_keypad_scan_debounce;

   localparam int unsigned Rows  = 4;
   localparam int unsigned Cols  = 3;
   localparam int unsigned CodeW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [11:0] keys = '0;

   logic [Cols-1:0]  col_a, col_b;
   logic [Rows-1:0]  row_a, row_b;
   logic [CodeW-1:0] code_a, code_b;
   logic valid_a, press_a, rel_a, rep_a, multi_a;
   logic valid_b, press_b, rel_b, rep_b, multi_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Passive matrix: a held key connects its row line to its column line.
   function automatic logic [Cols-1:0] cols_for(input logic [Rows-1:0] row, input logic [11:0] k);
      logic [Cols-1:0] c;
      c = '0;
      for (int r = 0; r < Rows; r++)
         for (int j = 0; j < Cols; j++)
            if (row[Rows-1-r] && k[r*Cols+j]) c[Cols-1-j] = 1'b1;
      return c;
   endfunction

   assign col_a = cols_for(row_a, keys);
   assign col_b = cols_for(row_b, keys);

   keypad_scan_debounce #(
      .ROWS (Rows), .COLS (Cols), .SCAN_DIV (4), .DEBOUNCE_FRAMES (3),
      .REPEAT_EN (1'b0), .REPEAT_DELAY (32), .REPEAT_RATE (8)
   ) dut (
      .clk (clk), .rst (rst), .key_col_i (col_a), .key_row_o (row_a), .key_code_o (code_a),
      .key_valid_o (valid_a), .key_press_o (press_a), .key_release_o (rel_a),
      .key_repeat_o (rep_a), .multi_key_o (multi_a)
   );

   keypad_scan_debounce #(
      .ROWS (Rows), .COLS (Cols), .SCAN_DIV (4), .DEBOUNCE_FRAMES (3),
      .REPEAT_EN (1'b1), .REPEAT_DELAY (4), .REPEAT_RATE (2)
   ) dut_rep (
      .clk (clk), .rst (rst), .key_col_i (col_b), .key_row_o (row_b), .key_code_o (code_b),
      .key_valid_o (valid_b), .key_press_o (press_b), .key_release_o (rel_b),
      .key_repeat_o (rep_b), .multi_key_o (multi_b)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Leaves time at 1 unit after the first edge out of reset: start of frame 0, row 0 driven.
   task automatic do_reset();
      rst  = 1'b1;
      keys = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      logic [3:0] exp_row;
      logic       any;
      rst  = 1'b1;
      keys = '0;
      tick(2);
      checks++;
      if ({row_a, code_a, valid_a, press_a, rel_a, rep_a, multi_a} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0",
                  {row_a, code_a, valid_a, press_a, rel_a, rep_a, multi_a});
      end
      rst = 1'b0;
      tick(1);
      for (int i = 0; i < 5; i++) begin
         exp_row = (i < 4) ? 4'b1000 : 4'b0100;
         checks++;
         if (row_a !== exp_row) begin
            errors++;
            $display("FAIL reset_row_drive[%0d]: got %b required %b", i, row_a, exp_row);
         end
         tick(1);
      end
      any = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if ({code_a, valid_a, press_a, rel_a, rep_a, multi_a} !== 9'd0) any = 1'b1;
         tick(1);
      end
      checks++;
      if (any !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_quiet: got activity %b required 0", any);
      end
   endtask

   task automatic test_clean_press();
      int n;
      do_reset();
      keys[4] = 1'b1;
      tick(47);
      checks++;
      if (press_a !== 1'b0 || valid_a !== 1'b0) begin
         errors++;
         $display("FAIL press_early: got press=%b valid=%b required 0 0", press_a, valid_a);
      end
      tick(1);
      checks++;
      if (press_a !== 1'b1) begin
         errors++;
         $display("FAIL press_pulse: got %b required 1", press_a);
      end
      checks++;
      if (code_a !== 4'd4 || valid_a !== 1'b1) begin
         errors++;
         $display("FAIL press_code: got code=%0d valid=%b required 4 1", code_a, valid_a);
      end
      tick(1);
      checks++;
      if (press_a !== 1'b0) begin
         errors++;
         $display("FAIL press_width: got %b required 0", press_a);
      end
      n = 0;
      for (int i = 0; i < 47; i++) begin
         tick(1);
         if (press_a) n++;
      end
      checks++;
      if (n !== 0 || valid_a !== 1'b1 || code_a !== 4'd4) begin
         errors++;
         $display("FAIL press_hold: got presses=%0d valid=%b code=%0d required 0 1 4",
                  n, valid_a, code_a);
      end
      keys[4] = 1'b0;
      tick(47);
      checks++;
      if (rel_a !== 1'b0) begin
         errors++;
         $display("FAIL release_early: got %b required 0", rel_a);
      end
      tick(1);
      checks++;
      if (rel_a !== 1'b1 || code_a !== 4'd4) begin
         errors++;
         $display("FAIL release_pulse: got rel=%b code=%0d required 1 4", rel_a, code_a);
      end
      tick(1);
      checks++;
      if (rel_a !== 1'b0 || valid_a !== 1'b0) begin
         errors++;
         $display("FAIL release_after: got rel=%b valid=%b required 0 0", rel_a, valid_a);
      end
   endtask

   task automatic test_bounce();
      int n, v, at;
      do_reset();
      n = 0;
      v = 0;
      for (int f = 0; f < 10; f++) begin
         keys[4] = (f % 2 == 0);
         for (int i = 0; i < 16; i++) begin
            if (press_a) n++;
            if (valid_a) v++;
            tick(1);
         end
      end
      checks++;
      if (n !== 0 || v !== 0) begin
         errors++;
         $display("FAIL bounce_reject: got presses=%0d valid_cycles=%0d required 0 0", n, v);
      end
      keys[4] = 1'b1;
      n  = 0;
      at = -1;
      for (int i = 0; i < 64; i++) begin
         if (press_a) begin
            n++;
            at = i;
         end
         tick(1);
      end
      checks++;
      if (n !== 1 || at !== 48) begin
         errors++;
         $display("FAIL bounce_settle: got presses=%0d at=%0d required 1 at 48", n, at);
      end
   endtask

   task automatic test_multi_key();
      int n;
      do_reset();
      keys[6] = 1'b1;
      keys[8] = 1'b1;
      tick(15);
      checks++;
      if (multi_a !== 1'b0) begin
         errors++;
         $display("FAIL multi_before_frame: got %b required 0", multi_a);
      end
      tick(1);
      checks++;
      if (multi_a !== 1'b1) begin
         errors++;
         $display("FAIL multi_flag: got %b required 1", multi_a);
      end
      n = 0;
      for (int i = 0; i < 64; i++) begin
         if (press_a) n++;
         tick(1);
      end
      checks++;
      if (n !== 0 || multi_a !== 1'b1 || valid_a !== 1'b0) begin
         errors++;
         $display("FAIL multi_reject: got presses=%0d multi=%b valid=%b required 0 1 0",
                  n, multi_a, valid_a);
      end
      keys[8] = 1'b0;
      tick(16);
      checks++;
      if (multi_a !== 1'b0) begin
         errors++;
         $display("FAIL multi_clear: got %b required 0", multi_a);
      end
      tick(31);
      checks++;
      if (press_a !== 1'b0) begin
         errors++;
         $display("FAIL multi_press_early: got %b required 0", press_a);
      end
      tick(1);
      checks++;
      if (press_a !== 1'b1 || code_a !== 4'd6) begin
         errors++;
         $display("FAIL multi_single_press: got press=%b code=%0d required 1 6", press_a, code_a);
      end
   endtask

   task automatic test_swap_release();
      do_reset();
      keys[7] = 1'b1;
      tick(48);
      checks++;
      if (press_a !== 1'b1 || code_a !== 4'd7) begin
         errors++;
         $display("FAIL swap_first_press: got press=%b code=%0d required 1 7", press_a, code_a);
      end
      tick(16);
      keys[7]  = 1'b0;
      keys[10] = 1'b1;
      tick(48);
      checks++;
      if (rel_a !== 1'b1 || press_a !== 1'b0 || code_a !== 4'd7) begin
         errors++;
         $display("FAIL swap_release: got rel=%b press=%b code=%0d required 1 0 7",
                  rel_a, press_a, code_a);
      end
      tick(1);
      checks++;
      if (press_a !== 1'b1 || rel_a !== 1'b0 || code_a !== 4'd10 || valid_a !== 1'b1) begin
         errors++;
         $display("FAIL swap_press: got press=%b rel=%b code=%0d valid=%b required 1 0 10 1",
                  press_a, rel_a, code_a, valid_a);
      end
      tick(15);
      keys = '0;
      tick(48);
      checks++;
      if (rel_a !== 1'b1 || code_a !== 4'd10) begin
         errors++;
         $display("FAIL final_release: got rel=%b code=%0d required 1 10", rel_a, code_a);
      end
      tick(1);
      checks++;
      if (valid_a !== 1'b0 || rel_a !== 1'b0) begin
         errors++;
         $display("FAIL final_idle: got valid=%b rel=%b required 0 0", valid_a, rel_a);
      end
   endtask

   task automatic test_repeat_reset();
      logic exp;
      int   n;
      do_reset();
      keys[4] = 1'b1;
      for (int t = 0; t < 180; t++) begin
         exp = (t == 112 || t == 144 || t == 176);
         checks++;
         if (rep_b !== exp) begin
            errors++;
            $display("FAIL repeat_pulse[t=%0d]: got %b required %b", t, rep_b, exp);
         end
         if (t == 48) begin
            checks++;
            if (press_b !== 1'b1 || code_b !== 4'd4) begin
               errors++;
               $display("FAIL repeat_press: got press=%b code=%0d required 1 4", press_b, code_b);
            end
         end
         if (rep_a !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL repeat_disabled[t=%0d]: got %b required 0", t, rep_a);
         end
         tick(1);
      end
      checks++;
      if (valid_b !== 1'b1) begin
         errors++;
         $display("FAIL repeat_held: got valid=%b required 1", valid_b);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({row_b, code_b, valid_b, press_b, rel_b, rep_b, multi_b} !== 13'd0) begin
         errors++;
         $display("FAIL reset_mid_hold: got %b required 0",
                  {row_b, code_b, valid_b, press_b, rel_b, rep_b, multi_b});
      end
      tick(1);
      rst = 1'b0;
      n = 0;
      for (int i = 0; i < 64; i++) begin
         if (rel_b) n++;
         tick(1);
      end
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL reset_no_release: got %0d release pulses required 0", n);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_multi_key();
      test_swap_release();
      test_repeat_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
